// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control-byte bit indices,
// access size codes and the request FSM state encoding.
package mem_access_stage_pkg;

    localparam int WB_REG_WRITE  = 0;
    localparam int WB_MEM_TO_REG = 1;

    localparam int MEM_READ      = 0;
    localparam int MEM_WRITE     = 1;
    localparam int MEM_SIZE_LO   = 2;
    localparam int MEM_SIZE_HI   = 3;
    localparam int MEM_UNSIGNED  = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_RSVD = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // The reserved size code behaves as a full word access.
    function automatic logic [1:0] eff_size(input logic [1:0] size);
        logic [1:0] res;
        case (size)
            SIZE_BYTE: res = SIZE_BYTE;
            SIZE_HALF: res = SIZE_HALF;
            default:   res = SIZE_WORD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_store_align.sv
// Load_Store_Align: little-endian byte-enable/store-lane generation, load lane
// extraction with optional sign extension, and misalignment detection.
module mem_access_stage_load_store_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_en,
    output logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [1:0]  size_s;
    logic [7:0]  byte_lane_s;
    logic [15:0] half_lane_s;

    assign size_s      = eff_size(size);
    assign byte_lane_s = read_word[{addr_lo, 3'b000} +: 8];
    assign half_lane_s = addr_lo[1] ? read_word[31:16] : read_word[15:0];

    // Per-size lane steering for both directions plus alignment check.
    always_comb begin
        byte_en    = 4'b1111;
        write_data = store_data;
        load_data  = read_word;
        misalign   = 1'b0;
        case (size_s)
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                write_data = {4{store_data[7:0]}};
                load_data  = is_unsigned ? {24'h000000, byte_lane_s}
                                         : {{24{byte_lane_s[7]}}, byte_lane_s};
                misalign   = 1'b0;
            end
            SIZE_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                write_data = {2{store_data[15:0]}};
                load_data  = is_unsigned ? {16'h0000, half_lane_s}
                                         : {{16{half_lane_s[15]}}, half_lane_s};
                misalign   = addr_lo[0];
            end
            default: begin
                byte_en    = 4'b1111;
                write_data = store_data;
                load_data  = read_word;
                misalign   = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: drives the req/ack data-memory handshake, stalls the pipe
// while an access is outstanding and holds the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int NB_BITS = 32,
    parameter int NB_CTL  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_alu_out,
    input  logic [NB_BITS-1:0] i_data_reg,
    input  logic [4:0]         i_reg_dst,
    input  logic [NB_CTL-1:0]  i_wb_ctl,
    input  logic [NB_CTL-1:0]  i_mem_ctl,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [NB_BITS-1:0] o_mem_addr,
    output logic [NB_BITS-1:0] o_mem_wdata,
    output logic [3:0]         o_mem_be,
    input  logic [NB_BITS-1:0] i_mem_rdata,
    input  logic               i_mem_ack,
    output logic               o_stall,
    output logic               o_misalign,
    output logic [NB_CTL-1:0]  o_wb_ctl,
    output logic [NB_BITS-1:0] o_read_data,
    output logic [NB_BITS-1:0] o_alu_out,
    output logic [4:0]         o_reg_dst,
    output logic [NB_BITS-1:0] o_wb_data
);

    state_e              state_r, state_next_s;
    logic                access_s, write_s, go_s, misalign_raw_s, misalign_s;
    logic                req_s, stall_s, capture_s;
    logic [NB_BITS-1:0]  load_data_s;
    logic [NB_CTL-1:0]   wb_ctl_capt_s;
    logic [NB_CTL-1:0]   wb_ctl_r;
    logic [NB_BITS-1:0]  read_data_r, alu_out_r;
    logic [4:0]          reg_dst_r;
    logic                misalign_r;
    logic                unused_mem_ctl_s;

    assign unused_mem_ctl_s = ^i_mem_ctl[NB_CTL-1:MEM_UNSIGNED+1];

    assign access_s   = i_mem_ctl[MEM_READ] | i_mem_ctl[MEM_WRITE];
    assign write_s    = i_mem_ctl[MEM_WRITE];
    assign misalign_s = access_s & misalign_raw_s;
    assign go_s       = access_s & ~misalign_raw_s;

    mem_access_stage_load_store_align u_align (
        .addr_lo     (i_alu_out[1:0]),
        .size        (i_mem_ctl[MEM_SIZE_HI:MEM_SIZE_LO]),
        .is_unsigned (i_mem_ctl[MEM_UNSIGNED]),
        .store_data  (i_data_reg),
        .read_word   (i_mem_rdata),
        .byte_en     (o_mem_be),
        .write_data  (o_mem_wdata),
        .load_data   (load_data_s),
        .misalign    (misalign_raw_s)
    );

    // Request FSM: decides request, stall and when MEM/WB may capture.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        stall_s      = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (go_s) begin
                    req_s = 1'b1;
                    if (i_mem_ack) begin
                        capture_s = 1'b1;
                    end else begin
                        stall_s      = 1'b1;
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    capture_s = 1'b1;
                end
            end
            ST_WAIT: begin
                req_s = 1'b1;
                if (i_mem_ack) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // A misaligned access must never write back, so reg_write is cleared.
    assign wb_ctl_capt_s = misalign_s ? {i_wb_ctl[NB_CTL-1:1], 1'b0} : i_wb_ctl;

    // MEM/WB pipeline register and misalign pulse.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wb_ctl_r    <= {NB_CTL{1'b0}};
            read_data_r <= {NB_BITS{1'b0}};
            alu_out_r   <= {NB_BITS{1'b0}};
            reg_dst_r   <= 5'd0;
            misalign_r  <= 1'b0;
        end else begin
            misalign_r <= capture_s & misalign_s;
            if (capture_s) begin
                wb_ctl_r    <= wb_ctl_capt_s;
                read_data_r <= (go_s & ~write_s) ? load_data_s : {NB_BITS{1'b0}};
                alu_out_r   <= i_alu_out;
                reg_dst_r   <= i_reg_dst;
            end else begin
                wb_ctl_r    <= wb_ctl_r;
                read_data_r <= read_data_r;
                alu_out_r   <= alu_out_r;
                reg_dst_r   <= reg_dst_r;
            end
        end
    end

    // Request and stall are gated by reset so they drop without waiting for a clock.
    assign o_mem_req  = req_s & i_rst;
    assign o_stall    = stall_s & i_rst;
    assign o_mem_we   = o_mem_req & write_s;
    assign o_mem_addr = {i_alu_out[NB_BITS-1:2], 2'b00};

    assign o_misalign  = misalign_r;
    assign o_wb_ctl    = wb_ctl_r;
    assign o_read_data = read_data_r;
    assign o_alu_out   = alu_out_r;
    assign o_reg_dst   = reg_dst_r;
    assign o_wb_data   = wb_ctl_r[WB_MEM_TO_REG] ? read_data_r : alu_out_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus random
// accesses against an arithmetic reference model, with the bench acting as memory.
module tb_mem_access_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_alu_out, i_data_reg, i_mem_rdata;
    logic [4:0]  i_reg_dst;
    logic [7:0]  i_wb_ctl, i_mem_ctl;
    logic        i_mem_ack;
    logic        o_mem_req, o_mem_we, o_stall, o_misalign;
    logic [31:0] o_mem_addr, o_mem_wdata, o_read_data, o_alu_out, o_wb_data;
    logic [3:0]  o_mem_be;
    logic [7:0]  o_wb_ctl;
    logic [4:0]  o_reg_dst;

    int tests_run = 0;
    int tests_failed = 0;

    mem_access_stage dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_alu_out   (i_alu_out),
        .i_data_reg  (i_data_reg),
        .i_reg_dst   (i_reg_dst),
        .i_wb_ctl    (i_wb_ctl),
        .i_mem_ctl   (i_mem_ctl),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_be    (o_mem_be),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack),
        .o_stall     (o_stall),
        .o_misalign  (o_misalign),
        .o_wb_ctl    (o_wb_ctl),
        .o_read_data (o_read_data),
        .o_alu_out   (o_alu_out),
        .o_reg_dst   (o_reg_dst),
        .o_wb_data   (o_wb_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction through the stage; memory acks after nw cycles (if a request is due).
    task automatic do_op(input logic [31:0] alu, input logic [31:0] data, input logic [4:0] dst,
                         input logic [7:0] wb, input logic [7:0] mc,
                         input logic [31:0] rdata, input int nw_in);
        int nb, off, nw;
        bit acc, wr, mis, go;
        logic [31:0] mask, lane, exp_wdata, exp_rd, exp_wbdata;
        logic [3:0]  exp_be;
        logic [7:0]  exp_wb;

        nb   = (mc[3:2] == 2'b00) ? 1 : (mc[3:2] == 2'b01) ? 2 : 4;
        off  = int'(alu % 32'd4);
        acc  = mc[0] | mc[1];
        wr   = mc[1];
        mis  = acc && ((off % nb) != 0);
        go   = acc && !mis;
        nw   = go ? nw_in : 0;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        exp_be    = 4'(((1 << nb) - 1) << off);
        exp_wdata = (data & mask) * ((nb == 1) ? 32'h0101_0101 : (nb == 2) ? 32'h0001_0001 : 32'd1);
        lane = (rdata >> (8 * off)) & mask;
        if (!mc[4] && nb < 4 && lane[8 * nb - 1]) lane = lane | ~mask;
        exp_rd     = (go && !wr) ? lane : 32'd0;
        exp_wb     = (acc && mis) ? (wb & 8'hFE) : wb;
        exp_wbdata = exp_wb[1] ? exp_rd : alu;

        i_alu_out = alu; i_data_reg = data; i_reg_dst = dst; i_wb_ctl = wb; i_mem_ctl = mc;
        for (int k = 0; k <= nw; k++) begin
            if (k == nw) begin
                i_mem_ack = 1'b1; i_mem_rdata = rdata;
            end else begin
                i_mem_ack = 1'b0; i_mem_rdata = $urandom;
            end
            #1;
            chk("req", o_mem_req, go);
            chk("stall", o_stall, go && (k < nw));
            if (go) begin
                chk("we", o_mem_we, wr);
                chk("addr", o_mem_addr, alu & 32'hFFFF_FFFC);
                chk("be", o_mem_be, exp_be);
                if (wr) chk("wdata", o_mem_wdata, exp_wdata);
            end
            @(posedge i_clk); #2;
            i_mem_ack = 1'b0;
        end
        chk("wb_ctl", o_wb_ctl, exp_wb);
        chk("read_data", o_read_data, exp_rd);
        chk("alu_out", o_alu_out, alu);
        chk("reg_dst", o_reg_dst, dst);
        chk("wb_data", o_wb_data, exp_wbdata);
        chk("misalign", o_misalign, acc && mis);
    endtask

    initial begin
        logic [7:0]  mc;
        logic [31:0] addr;
        i_rst = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
        // Drive a load during reset: request and stall must stay low.
        i_alu_out = 32'h0000_0100; i_data_reg = 32'd0; i_reg_dst = 5'd3;
        i_wb_ctl = 8'h03; i_mem_ctl = 8'h0D;
        #1;
        chk("rst_req", o_mem_req, 1'b0);
        chk("rst_stall", o_stall, 1'b0);
        chk("rst_wb_ctl", o_wb_ctl, 32'd0);
        chk("rst_read_data", o_read_data, 32'd0);
        chk("rst_alu_out", o_alu_out, 32'd0);
        chk("rst_misalign", o_misalign, 1'b0);
        @(posedge i_clk); #2;
        i_mem_ctl = 8'h00; i_rst = 1'b1;

        do_op(32'h0000_0103, 32'h0000_00AB, 5'd0, 8'h00, 8'h02, 32'h0, 0);
        do_op(32'h0000_0102, 32'h0, 5'd4, 8'h03, 8'h05, 32'h8001_1234, 3);
        chk("half_signed_const", o_read_data, 32'hFFFF_8001);
        do_op(32'h0000_0102, 32'h0, 5'd4, 8'h03, 8'h15, 32'h8001_1234, 3);
        chk("half_unsigned_const", o_read_data, 32'h0000_8001);
        do_op(32'h0000_0101, 32'h0, 5'd6, 8'h03, 8'h0D, 32'hDEAD_BEEF, 0);
        do_op(32'h0000_0055, 32'h0, 5'd9, 8'h01, 8'h00, 32'h1234_5678, 0);
        chk("rtype_wb_data_const", o_wb_data, 32'h0000_0055);
        do_op(32'h0000_0200, 32'h0, 5'd1, 8'h03, 8'h0D, 32'hCAFE_F00D, 1);
        do_op(32'h0000_0201, 32'h0, 5'd2, 8'h03, 8'h01, 32'h0000_9A00, 1);

        for (int i = 0; i < 60; i++) begin
            mc   = 8'($urandom_range(0, 31)) | (8'($urandom_range(0, 7)) << 5);
            addr = $urandom;
            do_op(addr, $urandom, 5'($urandom), 8'($urandom), mc, $urandom, $urandom_range(0, 3));
        end

        // Reset asserted while a load is waiting.
        do_op(32'h0000_0077, 32'h0, 5'd12, 8'h05, 8'h00, 32'h0, 0);
        i_alu_out = 32'h0000_0300; i_mem_ctl = 8'h0D; i_wb_ctl = 8'h03; i_reg_dst = 5'd7;
        i_mem_ack = 1'b0;
        #1;
        chk("wait_stall0", o_stall, 1'b1);
        @(posedge i_clk); #2;
        chk("wait_stall1", o_stall, 1'b1);
        chk("wait_req1", o_mem_req, 1'b1);
        i_rst = 1'b0;
        #1;
        chk("midrst_req", o_mem_req, 1'b0);
        chk("midrst_stall", o_stall, 1'b0);
        chk("midrst_alu_out", o_alu_out, 32'd0);
        chk("midrst_reg_dst", o_reg_dst, 32'd0);
        chk("midrst_wb_ctl", o_wb_ctl, 32'd0);
        @(posedge i_clk); #2;
        i_mem_ctl = 8'h00; i_alu_out = 32'd0; i_wb_ctl = 8'h00; i_reg_dst = 5'd0;
        i_rst = 1'b1; i_mem_ack = 1'b1; i_mem_rdata = 32'h5555_AAAA;
        #1;
        chk("late_ack_req", o_mem_req, 1'b0);
        chk("late_ack_stall", o_stall, 1'b0);
        @(posedge i_clk); #2;
        i_mem_ack = 1'b0;
        chk("late_ack_read_data", o_read_data, 32'd0);
        do_op(32'h0000_0400, 32'h0, 5'd8, 8'h03, 8'h0D, 32'h0BAD_CAFE, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the MIPS core. It consumes the EX/MEM register fields (ALU result, store data, destination register, WB/MEM control bytes) and performs byte/half/word loads and stores against an external data memory using a req/ack handshake, stalling the pipe while an access is outstanding. It captures the result into the MEM/WB register that feeds writeback and the `i_mem_wb_reg_hz` forwarding path of the execution stage.

## Interface
- `NB_BITS`, 32: datapath and address width; only 32 is supported.
- `NB_CTL`, 8: width of the WB and MEM control bytes.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `i_alu_out` in 32: EX/MEM ALU result, used as the byte address.
- `i_data_reg` in 32: EX/MEM store data (rt).
- `i_reg_dst` in 5: EX/MEM destination register.
- `i_wb_ctl` in 8: bit0 reg_write, bit1 mem_to_reg, other bits passed through.
- `i_mem_ctl` in 8: bit0 mem_read, bit1 mem_write, [3:2] size (00 byte, 01 half, 10 reserved→word, 11 word), bit4 unsigned load.
- `o_mem_req` out 1: memory request.
- `o_mem_we` out 1: write enable, valid with req.
- `o_mem_addr` out 32: word-aligned address ({alu_out[31:2],2'b00}).
- `o_mem_wdata` out 32: lane-replicated store data.
- `o_mem_be` out 4: byte enables.
- `i_mem_rdata` in 32: read word, valid with ack.
- `i_mem_ack` in 1: access complete.
- `o_stall` out 1: to hazard unit; upstream stages hold while high.
- `o_misalign` out 1: registered, one-cycle pulse on a misaligned access.
- `o_wb_ctl` out 8, `o_read_data` out 32, `o_alu_out` out 32, `o_reg_dst` out 5: MEM/WB register.
- `o_wb_data` out 32: comb. writeback value (mem_to_reg ? o_read_data : o_alu_out), used for forwarding.

## Operation
- Access = mem_read | mem_write (write wins if both set). Little-endian lanes.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0. No request issued; MEM/WB captured with reg_write forced 0; o_misalign pulses.
- Store: byte → be = 1<<addr[1:0], wdata = {4{d[7:0]}}; half → be = addr[1]?1100:0011, wdata = {2{d[15:0]}}; word → be 1111, wdata = d.
- Load: select lane by addr[1:0], sign-extend unless bit4 set; word unchanged. o_mem_be reflects the size for reads too.
- FSM IDLE/WAIT:
  - IDLE, no access or misaligned: o_stall=0, capture MEM/WB every cycle.
  - IDLE, access: o_mem_req=1 combinationally. If i_mem_ack same cycle: capture, stay IDLE, o_stall=0. Else o_stall=1, go WAIT, no capture.
  - WAIT: hold req/we/addr/be/wdata from stable inputs; o_stall=1 until ack; on ack capture, o_stall=0 that cycle, go IDLE.
- Non-access instructions: o_read_data captured as 0.
- Ack outside a request is ignored.

## Timing
- Reset (i_rst=0): FSM→IDLE, all MEM/WB outputs 0, o_misalign 0; o_mem_req and o_stall forced 0 immediately (async), regardless of inputs.
- Reset mid-WAIT: request dropped; a late ack after release is ignored.
- Zero-wait memory: latency 1 cycle into MEM/WB, no stall. N-cycle ack: N stall cycles; MEM/WB updates on the ack edge.
- Inputs must stay constant while o_stall=1 (upstream contract); back-to-back accesses issue a new req the cycle after capture.

## Structure
- Shared include: mem_ctl/wb_ctl bit indices, size codes (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`), FSM state encodings.
- Sub-module `Load_Store_Align`: combinational be/wdata generation, lane extraction and sign-extension, misalign detect. Stage top holds FSM and MEM/WB register.

## Test plan
- Store byte, addr 0x103, data 0x000000AB, ack same cycle → be=1000, wdata=0xABABABAB, o_stall never high.
- Load signed half, addr 0x102, rdata 0x8001_1234, ack after 3 cycles → o_stall high 3 cycles, o_read_data=0xFFFF8001; unsigned variant → 0x00008001.
- Load word addr 0x101 → no req, o_misalign pulse, o_wb_ctl[0]=0.
- R-type pass-through, alu_out 0x55, reg_dst 9, wb_ctl 0x01 → next cycle o_alu_out=0x55, o_reg_dst=9, o_wb_data=0x55.
- Assert i_rst during WAIT → o_mem_req/o_stall drop immediately, outputs 0; ack after release has no effect.
- Two back-to-back loads, ack with 1-cycle wait each → two captures, correct data, stall pattern 1,0,1,0.
